gdma_axil_reg_bridge: RTL

//  AXI4-Lite slave bridging the Zynq PS GP port onto the GDMA register-file port (zynq2gdma_reg_*).

---
 rtl/gdma_reg_pkg.sv | 37 +++
 rtl/gdma_axil_hold.sv | 51 +++++
 rtl/gdma_axil_reg_bridge.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/gdma_reg_pkg.sv
// ============================================================================
// Module      : gdma_reg_pkg
// Description : Shared constants, FSM encoding and address helpers for the
//               GDMA AXI4-Lite register bridge.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package gdma_reg_pkg;

    localparam int ADDR_W   = 13;
    localparam int NUM_REGS = 26;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ISSUE = 3'd1,
        ST_WR_RESP  = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_CAP   = 3'd4,
        ST_RD_RESP  = 3'd5
    } state_t;

    function automatic logic [9:0] word_index(input logic [ADDR_W-1:0] addr);
        return addr[11:2];
    endfunction

    // Bit 12 selects a region the bank does not implement at all.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return (addr[ADDR_W-1] == 1'b0) && (word_index(addr) < 10'(NUM_REGS));
    endfunction

endpackage

`default_nettype wire

// File: rtl/gdma_axil_hold.sv
// ============================================================================
// Module      : gdma_axil_hold
// Description : One-entry valid/ready holding register with a same-cycle
//               bypass view of the incoming beat.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module gdma_axil_hold #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         clear,
    output logic         avail,
    output logic [W-1:0] data
);

    logic         r_live;
    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_take;

    // r_live keeps ready low during reset and for the edge that releases it.
    assign in_ready = r_live & ~r_valid;
    assign w_take   = in_valid & in_ready;
    assign avail    = r_valid | w_take;
    assign data     = r_valid ? r_data : in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_live <= 1'b1;
            if (clear) begin
                r_valid <= 1'b0;
            end else if (w_take) begin
                r_valid <= 1'b1;
                r_data  <= in_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/gdma_axil_reg_bridge.sv
// ============================================================================
// Module      : gdma_axil_reg_bridge
// Description : AXI4-Lite slave driving the GDMA register-file port; one
//               register access in flight, out-of-range accesses -> SLVERR.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module gdma_axil_reg_bridge
    import gdma_reg_pkg::*;
(
    input  logic              zynq2gdma_reg_clk,
    input  logic              zynq2gdma_reg_rst,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [31:0]       s_axil_wdata,
    input  logic [3:0]        s_axil_wstrb,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    output logic [1:0]        s_axil_bresp,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    input  logic [ADDR_W-1:0] s_axil_araddr,
    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    output logic [31:0]       s_axil_rdata,
    output logic [1:0]        s_axil_rresp,
    output logic              s_axil_rvalid,
    input  logic              s_axil_rready,
    output logic [ADDR_W-1:0] zynq2gdma_reg_addr,
    output logic [31:0]       zynq2gdma_reg_wrdata,
    output logic [3:0]        zynq2gdma_reg_we,
    output logic              zynq2gdma_reg_en,
    input  logic [31:0]       zynq2gdma_reg_rddata
);

    logic              w_aw_avail, w_w_avail, w_ar_avail;
    logic [ADDR_W-1:0] w_aw_addr, w_ar_addr;
    logic [35:0]       w_w_bits;
    logic              w_aw_clr, w_ar_clr;

    gdma_axil_hold #(.W(ADDR_W)) u_aw_hold (
        .clk(zynq2gdma_reg_clk), .rst(zynq2gdma_reg_rst),
        .in_data(s_axil_awaddr), .in_valid(s_axil_awvalid), .in_ready(s_axil_awready),
        .clear(w_aw_clr), .avail(w_aw_avail), .data(w_aw_addr)
    );

    gdma_axil_hold #(.W(36)) u_w_hold (
        .clk(zynq2gdma_reg_clk), .rst(zynq2gdma_reg_rst),
        .in_data({s_axil_wstrb, s_axil_wdata}), .in_valid(s_axil_wvalid), .in_ready(s_axil_wready),
        .clear(w_aw_clr), .avail(w_w_avail), .data(w_w_bits)
    );

    gdma_axil_hold #(.W(ADDR_W)) u_ar_hold (
        .clk(zynq2gdma_reg_clk), .rst(zynq2gdma_reg_rst),
        .in_data(s_axil_araddr), .in_valid(s_axil_arvalid), .in_ready(s_axil_arready),
        .clear(w_ar_clr), .avail(w_ar_avail), .data(w_ar_addr)
    );

    state_t            r_state, w_next;
    logic              r_prefer_rd;
    logic              r_hit;
    logic              r_en;
    logic [3:0]        r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wrdata;
    logic              r_bvalid, r_rvalid;
    logic [1:0]        r_bresp, r_rresp;
    logic [31:0]       r_rdata;

    logic w_wr_rdy, w_rd_rdy, w_go_wr, w_go_rd, w_issue_hit, w_collide;

    // Availability includes the beat arriving this cycle, so the grant and
    // the registered en land in the cycle right after the handshake.
    assign w_wr_rdy = w_aw_avail & w_w_avail & ~r_bvalid;
    assign w_rd_rdy = w_ar_avail;

    always_ff @(posedge zynq2gdma_reg_clk or posedge zynq2gdma_reg_rst) begin
        if (zynq2gdma_reg_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_rd_rdy && w_wr_rdy) begin
                    w_next = r_prefer_rd ? ST_RD_ISSUE : ST_WR_ISSUE;
                end else if (w_rd_rdy) begin
                    w_next = ST_RD_ISSUE;
                end else if (w_wr_rdy) begin
                    w_next = ST_WR_ISSUE;
                end
            end
            ST_WR_ISSUE: w_next = ST_WR_RESP;
            ST_WR_RESP:  if (s_axil_bready) w_next = ST_IDLE;
            ST_RD_ISSUE: w_next = ST_RD_CAP;
            ST_RD_CAP:   w_next = ST_RD_RESP;
            ST_RD_RESP:  if (s_axil_rready) w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_go_wr     = (r_state == ST_IDLE) && (w_next == ST_WR_ISSUE);
        w_go_rd     = (r_state == ST_IDLE) && (w_next == ST_RD_ISSUE);
        w_collide   = (r_state == ST_IDLE) && w_wr_rdy && w_rd_rdy;
        w_issue_hit = w_go_wr ? addr_in_range(w_aw_addr) : addr_in_range(w_ar_addr);
        w_aw_clr    = (r_state == ST_WR_ISSUE);
        w_ar_clr    = (r_state == ST_RD_CAP);
    end

    always_ff @(posedge zynq2gdma_reg_clk or posedge zynq2gdma_reg_rst) begin
        if (zynq2gdma_reg_rst) begin
            r_prefer_rd <= 1'b1;
            r_hit       <= 1'b0;
            r_en        <= 1'b0;
            r_we        <= '0;
            r_addr      <= '0;
            r_wrdata    <= '0;
            r_bvalid    <= 1'b0;
            r_bresp     <= RESP_OKAY;
            r_rvalid    <= 1'b0;
            r_rresp     <= RESP_OKAY;
            r_rdata     <= '0;
        end else begin
            r_en <= (w_go_wr | w_go_rd) & w_issue_hit;
            r_we <= (w_go_wr && w_issue_hit) ? w_w_bits[35:32] : 4'b0000;
            if (w_go_wr) begin
                r_addr   <= w_aw_addr;
                r_wrdata <= w_w_bits[31:0];
            end else if (w_go_rd) begin
                r_addr <= w_ar_addr;
            end
            if (w_go_wr || w_go_rd) begin
                r_hit <= w_issue_hit;
            end
            // Priority flips only on a genuine collision.
            if (w_collide) begin
                r_prefer_rd <= ~r_prefer_rd;
            end

            if (r_state == ST_WR_ISSUE) begin
                r_bvalid <= 1'b1;
                r_bresp  <= r_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (r_bvalid && s_axil_bready) begin
                r_bvalid <= 1'b0;
            end

            if (r_state == ST_RD_CAP) begin
                r_rvalid <= 1'b1;
                r_rdata  <= r_hit ? zynq2gdma_reg_rddata : 32'h0;
                r_rresp  <= r_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (r_rvalid && s_axil_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign zynq2gdma_reg_en     = r_en;
    assign zynq2gdma_reg_we     = r_we;
    assign zynq2gdma_reg_addr   = r_addr;
    assign zynq2gdma_reg_wrdata = r_wrdata;
    assign s_axil_bvalid        = r_bvalid;
    assign s_axil_bresp         = r_bresp;
    assign s_axil_rvalid        = r_rvalid;
    assign s_axil_rresp         = r_rresp;
    assign s_axil_rdata         = r_rdata;

endmodule

`default_nettype wire
